// File: rtl/number_frame_sched.sv
// rtl/number_frame_sched.sv - frame-rotated status value scheduler with iterative BCD conversion
// Digits are converted off the pixel path and committed only during vertical blanking.
module number_frame_sched #(
    parameter int unsigned FRAMES_PER_SRC = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic        hold_in,
    input  logic [12:0] number0_in,
    input  logic [12:0] number1_in,
    input  logic [12:0] number2_in,
    input  logic [12:0] number3_in,
    output logic [3:0]  hundreds_out,
    output logic [3:0]  tens_out,
    output logic [3:0]  ones_out,
    output logic [1:0]  src_sel_out,
    output logic        overflow_out,
    output logic        busy_out,
    output logic        update_out
);

    localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_SRC - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        WAIT_BLANK
    } state_t;

    state_t      state_q, state_d;
    logic        vsync_q;
    logic        armed_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [9:0]  value_q, value_d;
    logic [11:0] bcd_q, bcd_d;
    logic [3:0]  iter_q, iter_d;
    logic [1:0]  pend_sel_q, pend_sel_d;
    logic        pend_ovf_q, pend_ovf_d;
    logic [3:0]  hund_q, tens_q, ones_q;
    logic [1:0]  src_sel_q;
    logic        ovf_q;
    logic        upd_q;
    logic        commit;
    logic        frame_start;
    logic [12:0] sel_number;
    logic        sel_ovf;
    logic [2:0]  hund_adj;
    logic [3:0]  tens_adj, ones_adj;

    // armed_q blocks a vsync that is already high when reset releases from counting as an edge
    assign frame_start = vsync_in & ~vsync_q & armed_q;

    always_comb begin
        cnt_d = cnt_q;
        sel_d = sel_q;
        if (frame_start) begin
            if (!hold_in && (cnt_q == CNT_LAST)) begin
                cnt_d = 8'd0;
                sel_d = sel_q + 2'd1;
            end else if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        sel_number = number0_in;
        case (sel_d)
            2'd0:    sel_number = number0_in;
            2'd1:    sel_number = number1_in;
            2'd2:    sel_number = number2_in;
            default: sel_number = number3_in;
        endcase
    end

    assign sel_ovf = (sel_number > 13'd999);

    // The hundreds nibble's top bit is shifted out, so only its low 3 bits need adjusting
    always_comb begin
        hund_adj = (bcd_q[11:8] >= 4'd5) ? (bcd_q[10:8] + 3'd3) : bcd_q[10:8];
        tens_adj = (bcd_q[7:4]  >= 4'd5) ? (bcd_q[7:4]  + 4'd3) : bcd_q[7:4];
        ones_adj = (bcd_q[3:0]  >= 4'd5) ? (bcd_q[3:0]  + 4'd3) : bcd_q[3:0];
    end

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        pend_sel_d = pend_sel_q;
        pend_ovf_d = pend_ovf_q;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    value_d    = sel_ovf ? 10'd999 : sel_number[9:0];
                    pend_ovf_d = sel_ovf;
                    pend_sel_d = sel_d;
                    bcd_d      = 12'd0;
                    iter_d     = 4'd0;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d   = {hund_adj, tens_adj, ones_adj, value_q[9]};
                value_d = {value_q[8:0], 1'b0};
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd9) begin
                    state_d = WAIT_BLANK;
                end
            end
            WAIT_BLANK: begin
                if (vblnk_in) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            vsync_q    <= 1'b0;
            armed_q    <= 1'b0;
            cnt_q      <= 8'd0;
            sel_q      <= 2'd0;
            value_q    <= 10'd0;
            bcd_q      <= 12'd0;
            iter_q     <= 4'd0;
            pend_sel_q <= 2'd0;
            pend_ovf_q <= 1'b0;
            hund_q     <= 4'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            src_sel_q  <= 2'd0;
            ovf_q      <= 1'b0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= vsync_in;
            armed_q    <= armed_q | ~vsync_in;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            value_q    <= value_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            pend_sel_q <= pend_sel_d;
            pend_ovf_q <= pend_ovf_d;
            upd_q      <= commit;
            if (commit) begin
                hund_q    <= bcd_q[11:8];
                tens_q    <= bcd_q[7:4];
                ones_q    <= bcd_q[3:0];
                src_sel_q <= pend_sel_q;
                ovf_q     <= pend_ovf_q;
            end
        end
    end

    assign hundreds_out = hund_q;
    assign tens_out     = tens_q;
    assign ones_out     = ones_q;
    assign src_sel_out  = src_sel_q;
    assign overflow_out = ovf_q;
    assign update_out   = upd_q;
    assign busy_out     = (state_q != IDLE);

endmodule

// File: tb/tb_number_frame_sched.sv
// tb/tb_number_frame_sched.sv - directed self-checking bench for number_frame_sched
module tb_number_frame_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync_in;
    logic        vblnk_in;
    logic        hold_in;
    logic [12:0] number0_in, number1_in, number2_in, number3_in;
    logic [3:0]  hundreds_out, tens_out, ones_out;
    logic [1:0]  src_sel_out;
    logic        overflow_out, busy_out, update_out;

    int n_asserts = 0;
    int n_fails   = 0;
    int cyc;

    number_frame_sched #(.FRAMES_PER_SRC(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .vsync_in     (vsync_in),
        .vblnk_in     (vblnk_in),
        .hold_in      (hold_in),
        .number0_in   (number0_in),
        .number1_in   (number1_in),
        .number2_in   (number2_in),
        .number3_in   (number3_in),
        .hundreds_out (hundreds_out),
        .tens_out     (tens_out),
        .ones_out     (ones_out),
        .src_sel_out  (src_sel_out),
        .overflow_out (overflow_out),
        .busy_out     (busy_out),
        .update_out   (update_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic start_frame();
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
    endtask

    task automatic wait_update(output int cycles);
        int found;
        cycles = 0;
        found  = 0;
        while (found == 0 && cycles < 100) begin
            tick();
            cycles++;
            if (update_out === 1'b1) found = 1;
        end
        chk("update_seen", found, 1);
    endtask

    task automatic chk_digits(input string tag, input int h, input int t, input int o, input int ovf, input int s);
        chk({tag, "_hund"}, hundreds_out, h);
        chk({tag, "_tens"}, tens_out, t);
        chk({tag, "_ones"}, ones_out, o);
        chk({tag, "_ovf"},  overflow_out, ovf);
        chk({tag, "_sel"},  src_sel_out, s);
    endtask

    int ovf_num [3] = '{1234, 999, 0};
    int ovf_h   [3] = '{9, 9, 0};
    int ovf_t   [3] = '{9, 9, 0};
    int ovf_o   [3] = '{9, 9, 0};
    int ovf_f   [3] = '{1, 0, 0};
    int rot_sel [8] = '{0, 1, 1, 2, 2, 3, 3, 0};

    initial begin
        rst = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0; hold_in = 1'b0;
        number0_in = 13'd0; number1_in = 13'd0; number2_in = 13'd0; number3_in = 13'd0;
        repeat (3) tick();
        chk_digits("reset", 0, 0, 0, 0, 0);
        chk("reset_busy", busy_out, 0);
        chk("reset_update", update_out, 0);

        // Basic conversion with fixed 11-clock latency
        rst = 1'b1; hold_in = 1'b1; vblnk_in = 1'b1; number0_in = 13'd407;
        repeat (2) tick();
        start_frame();
        chk("conv_busy", busy_out, 1);
        wait_update(cyc);
        chk("conv_latency", cyc, 11);
        chk_digits("conv407", 4, 0, 7, 0, 0);
        tick();
        chk("conv_update_drop", update_out, 0);
        chk("conv_idle", busy_out, 0);

        for (int i = 0; i < 3; i++) begin
            number0_in = 13'(ovf_num[i]);
            start_frame();
            wait_update(cyc);
            chk_digits("clamp", ovf_h[i], ovf_t[i], ovf_o[i], ovf_f[i], 0);
        end

        // Rotation from a fresh counter state
        rst = 1'b0; tick(); rst = 1'b1; tick();
        hold_in = 1'b0;
        number0_in = 13'd11; number1_in = 13'd22; number2_in = 13'd33; number3_in = 13'd44;
        for (int i = 0; i < 8; i++) begin
            start_frame();
            wait_update(cyc);
            chk("rot_sel", src_sel_out, rot_sel[i]);
            chk("rot_tens", tens_out, rot_sel[i] + 1);
            chk("rot_ones", ones_out, rot_sel[i] + 1);
        end
        hold_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_frame();
            wait_update(cyc);
            chk("hold_sel", src_sel_out, 0);
            chk("hold_ones", ones_out, 1);
        end

        // Commit deferred until blanking
        number0_in = 13'd123; vblnk_in = 1'b0;
        start_frame();
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("defer_busy", busy_out, 1);
            chk("defer_update", update_out, 0);
            chk("defer_ones_old", ones_out, 1);
        end
        vblnk_in = 1'b1;
        tick();
        chk("defer_update_on_blank", update_out, 1);
        chk_digits("defer", 1, 2, 3, 0, 0);

        // Second frame start during conversion is dropped but advances the counter
        hold_in = 1'b0;
        start_frame();
        repeat (4) tick();
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("drop_no_update", update_out, 0);
        end
        tick();
        chk("drop_commit_k11", update_out, 1);
        chk_digits("drop", 0, 2, 2, 0, 1);
        start_frame();
        wait_update(cyc);
        chk_digits("drop_next", 0, 3, 3, 0, 2);

        // Asynchronous reset aborts a conversion
        start_frame();
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        chk_digits("abort", 0, 0, 0, 0, 0);
        chk("abort_busy", busy_out, 0);
        chk("abort_update", update_out, 0);
        vsync_in = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("abort_high_vsync_idle", busy_out, 0);
        end
        vsync_in = 1'b0;
        tick();
        start_frame();
        chk("abort_restart_busy", busy_out, 1);
        wait_update(cyc);
        chk("abort_restart_latency", cyc, 11);
        chk_digits("abort_restart", 1, 2, 3, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/number_frame_sched.md
# number_frame_sched

Frame-synchronous value scheduler and sequential binary-to-BCD converter for the 3-digit status display chain. Once per frame it selects one of four 13-bit status values, rotating between them every FRAMES_PER_SRC frames. It clamps the selected value to 999 and converts it to three BCD digits using a 10-cycle iterative shift-add-3 loop, which removes the combinational /100, /10 and %10 dividers from the pixel path. It commits the digits to its outputs only during vertical blanking, so the downstream digit-drawing stages never show a torn value within a frame.

## Interface
- FRAMES_PER_SRC, 60, number of frame starts each source is shown before rotating; legal range 1..255.
- clk  in  1  pixel clock, rising-edge active.
- rst  in  1  asynchronous, active-low reset.
- vsync_in  in  1  vertical sync from the timing chain; a rising edge marks frame start.
- vblnk_in  in  1  vertical blanking; digits are committed only while this is high.
- hold_in  in  1  when high, source rotation is frozen and the current source is re-converted every frame.
- number0_in..number3_in  in  13 each  status values, unsigned.
- hundreds_out, tens_out, ones_out  out  4 each  committed BCD digits.
- src_sel_out  out  2  index of the source the committed digits came from.
- overflow_out  out  1  the committed value was clamped (source > 999).
- busy_out  out  1  a conversion or pending commit is in progress.
- update_out  out  1  one-cycle pulse on the cycle the digit outputs change.

## Operation
- Frame-start detect: register vsync_in into vsync_d; frame_start = vsync_in & ~vsync_d.
- Frame counter (8 bit) and source select (2 bit) advance on every frame_start, including while busy:
  - if hold_in = 0 and the counter = FRAMES_PER_SRC-1: the counter goes to 0 and the selection advances (3 wraps to 0);
  - otherwise the counter increments and saturates at FRAMES_PER_SRC-1, and the selection holds.
- FSM states: IDLE, CONVERT, WAIT_BLANK.
- IDLE, on frame_start:
  - latch the post-update selection's number into a 10-bit working value, clamped to 999;
  - set pend_ovf = (number > 999) and pend_sel = the new selection;
  - clear the 12-bit BCD register and the iteration count;
  - go to CONVERT.
- CONVERT, one iteration per cycle, 10 iterations:
  - add 3 to each BCD nibble that is ≥ 5;
  - shift {bcd, value} left by one.
  - After the 10th iteration go to WAIT_BLANK.
- WAIT_BLANK, on the first cycle with vblnk_in = 1:
  - load hundreds/tens/ones from the BCD register, src_sel_out from pend_sel and overflow_out from pend_ovf;
  - pulse update_out;
  - go to IDLE.
- A frame_start seen in CONVERT or WAIT_BLANK does not restart the conversion. It is dropped, apart from the counter and selection update. src_sel_out always reports the source of the digits currently displayed, not the live selection.
- busy_out = (state != IDLE).

## Timing
- On reset, every output is 0: digits 0/0/0, src_sel_out 0, overflow_out 0, busy_out 0, update_out 0. Internal state is also cleared: counter 0, selection 0, vsync_d 0, state IDLE.
- Reset asserted mid-conversion aborts the conversion; no commit follows. After release the block waits for the next vsync rising edge. A vsync_in already high at release does not count as an edge.
- Let k be the clock edge where frame_start = 1 in IDLE:
  - the latch happens at edge k;
  - CONVERT occupies edges k+1..k+10;
  - the earliest commit is edge k+11 (vblnk_in high), where the outputs and update_out = 1 become visible.
  - Minimum latency is 11 clocks. busy_out is high from after edge k until after the commit edge.
- With vblnk_in low, WAIT_BLANK holds indefinitely and the outputs keep their old values.
- Outputs are registered and never glitch; digits, src_sel_out and overflow_out change only together on the update_out cycle.

## Test plan
- Value conversion: FRAMES_PER_SRC=1, hold_in=1, number0_in=407, vblnk_in high -> after one vsync rise, exactly 11 clocks later digits 4/0/7, overflow_out 0, update_out high for 1 cycle.
- Overflow clamp: number0_in=1234 -> digits 9/9/9, overflow_out 1. Then 999 -> 9/9/9, overflow_out 0. Then 0 -> 0/0/0.
- Rotation: FRAMES_PER_SRC=2, hold_in=0, sources 11/22/33/44 -> src_sel_out sequence 0,1,1,2,2,3,3,0 over successive frames, with matching digits. Then hold_in=1 -> the selection freezes.
- Deferred commit: vblnk_in low for 50 clocks after the vsync rise -> busy_out stays high and the outputs are unchanged. vblnk_in rises at cycle 50 -> commit on that edge.
- Dropped frame: a second vsync rise at k+5 -> no restart; commit at k+11 carries the first value; the counter still advanced.
- Reset abort: rst low at k+4 -> all outputs 0 immediately (asynchronous). After release with vsync_in held high, no conversion starts until vsync falls and rises again.
